// File: rtl/font_rom_sequencer_if.sv
// Bundle between the font ROM sequencer, its two requesters and the font ROM.
// The slave side is the sequencer; the master side is everything around it.
interface font_rom_sequencer_if;
  logic       req0;
  logic       req1;
  logic [3:0] car0;
  logic [3:0] car1;
  logic [1:0] ad0;
  logic [1:0] ad1;
  logic [3:0] row0;
  logic [3:0] row1;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       gnt0;
  logic       gnt1;
  logic [3:0] rom_sel;
  logic [1:0] rom_ad;
  logic [3:0] rom_row;
  logic [7:0] rom_data;
  logic [7:0] rd_data;
  logic       rd_valid0;
  logic       rd_valid1;
  logic       rd_last;
  logic       busy;

  modport slave (
    input  req0, req1, car0, car1, ad0, ad1, row0, row1, len0, len1, rom_data,
    output gnt0, gnt1, rom_sel, rom_ad, rom_row, rd_data, rd_valid0, rd_valid1,
           rd_last, busy
  );

  modport master (
    output req0, req1, car0, car1, ad0, ad1, row0, row1, len0, len1, rom_data,
    input  gnt0, gnt1, rom_sel, rom_ad, rom_row, rd_data, rd_valid0, rd_valid1,
           rd_last, busy
  );
endinterface

// File: rtl/font_rom_sequencer.sv
// Arbitrates two glyph-row burst requesters onto one font ROM and streams
// the addressed rows back one per cycle to the winning requester.
module font_rom_sequencer #(
  parameter logic [3:0] SEL_BLANK = 4'd15
) (
  input logic                 clk,
  input logic                 reset,
  font_rom_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BURST0, BURST1} state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] romSel_q, romSel_d;
  logic [1:0] romAd_q, romAd_d;
  logic [3:0] romRow_q, romRow_d;
  logic [7:0] rdData_q, rdData_d;
  logic       rdValid0_q, rdValid0_d;
  logic       rdValid1_q, rdValid1_d;
  logic       rdLast_q, rdLast_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       lastGnt_q, lastGnt_d;
  logic       sync1_q, sync2_q;

  // Reset release passes through two flops so grants never race the release edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= 1'b1;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      romSel_q   <= SEL_BLANK;
      romAd_q    <= 2'd0;
      romRow_q   <= 4'd0;
      rdData_q   <= 8'h00;
      rdValid0_q <= 1'b0;
      rdValid1_q <= 1'b0;
      rdLast_q   <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      lastGnt_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      romSel_q   <= romSel_d;
      romAd_q    <= romAd_d;
      romRow_q   <= romRow_d;
      rdData_q   <= rdData_d;
      rdValid0_q <= rdValid0_d;
      rdValid1_q <= rdValid1_d;
      rdLast_q   <= rdLast_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      lastGnt_q  <= lastGnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    romSel_d   = romSel_q;
    romAd_d    = romAd_q;
    romRow_d   = romRow_q;
    rdData_d   = rdData_q;
    rdValid0_d = 1'b0;
    rdValid1_d = 1'b0;
    rdLast_d   = 1'b0;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    lastGnt_d  = lastGnt_q;

    case (state_q)
      IDLE: begin
        // lastGnt_q high means requester 1 went last, so requester 0 wins a tie.
        if (sync2_q && bus.req0 && (!bus.req1 || lastGnt_q)) begin
          state_d   = BURST0;
          gnt0_d    = 1'b1;
          romSel_d  = bus.car0;
          romAd_d   = bus.ad0;
          romRow_d  = bus.row0;
          cnt_d     = (bus.len0 == 4'd0) ? 5'd16 : {1'b0, bus.len0};
          lastGnt_d = 1'b0;
        end else if (sync2_q && bus.req1) begin
          state_d   = BURST1;
          gnt1_d    = 1'b1;
          romSel_d  = bus.car1;
          romAd_d   = bus.ad1;
          romRow_d  = bus.row1;
          cnt_d     = (bus.len1 == 4'd0) ? 5'd16 : {1'b0, bus.len1};
          lastGnt_d = 1'b1;
        end
      end
      BURST0, BURST1: begin
        rdData_d   = bus.rom_data;
        rdValid0_d = (state_q == BURST0);
        rdValid1_d = (state_q == BURST1);
        romRow_d   = romRow_q + 4'd1;
        cnt_d      = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          rdLast_d = 1'b1;
          state_d  = IDLE;
          romSel_d = SEL_BLANK;
          romAd_d  = 2'd0;
          romRow_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rom_sel   = romSel_q;
  assign bus.rom_ad    = romAd_q;
  assign bus.rom_row   = romRow_q;
  assign bus.rd_data   = rdData_q;
  assign bus.rd_valid0 = rdValid0_q;
  assign bus.rd_valid1 = rdValid1_q;
  assign bus.rd_last   = rdLast_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_font_rom_sequencer.sv
// Directed bench for font_rom_sequencer: stimulus pushes expected beats into a
// scoreboard queue and a negedge monitor pops and compares every returned beat.
module tb_font_rom_sequencer;

  localparam logic [3:0] SEL_BLANK = 4'd15;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b0;
  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];

  font_rom_sequencer_if bus();

  font_rom_sequencer #(.SEL_BLANK(SEL_BLANK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romModel(input logic [3:0] sel, input logic [1:0] ad,
                                          input logic [3:0] row);
    return {sel, row} ^ {ad, ad, ad, ad};
  endfunction

  assign bus.rom_data = romModel(bus.rom_sel, bus.rom_ad, bus.rom_row);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_gnt0",      32'(bus.gnt0),      32'd0);
    checkOutput("rst_gnt1",      32'(bus.gnt1),      32'd0);
    checkOutput("rst_rd_valid0", 32'(bus.rd_valid0), 32'd0);
    checkOutput("rst_rd_valid1", 32'(bus.rd_valid1), 32'd0);
    checkOutput("rst_rd_last",   32'(bus.rd_last),   32'd0);
    checkOutput("rst_busy",      32'(bus.busy),      32'd0);
    checkOutput("rst_rd_data",   32'(bus.rd_data),   32'd0);
    checkOutput("rst_rom_sel",   32'(bus.rom_sel),   32'(SEL_BLANK));
    checkOutput("rst_rom_ad",    32'(bus.rom_ad),    32'd0);
    checkOutput("rst_rom_row",   32'(bus.rom_row),   32'd0);
  endtask

  task automatic waitGrant(input int maxCycles, output int who);
    who = -1;
    for (int c = 0; c < maxCycles; c++) begin
      nextCycle();
      if (bus.gnt0 === 1'b1) begin
        who = 0;
        break;
      end
      if (bus.gnt1 === 1'b1) begin
        who = 1;
        break;
      end
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout: got no grant, expected one within %0d cycles", maxCycles);
    end
  endtask

  // otherMode: 0 none, 1 pulse the other request mid-burst, 2 raise and hold it,
  // 3 scramble this requester's fields the cycle after its grant.
  task automatic applyStimulus(input int id, input logic [3:0] car, input logic [1:0] ad,
                               input logic [3:0] row, input logic [3:0] len,
                               input int maxWait, input int otherMode,
                               input logic [1:0] dropMask);
    int         who;
    int         beats;
    logic [3:0] r;
    beats = (len == 4'd0) ? 16 : int'(len);
    for (int i = 0; i < beats; i++) begin
      r = row + 4'(i);
      sb.push_back('{id: id[0], data: romModel(car, ad, r), last: (i == beats - 1)});
    end
    waitGrant(maxWait, who);
    if (who < 0) return;
    checkOutput("grant_id", 32'(who), 32'(id));
    if (dropMask[0]) bus.req0 = 1'b0;
    if (dropMask[1]) bus.req1 = 1'b0;
    for (int i = 0; i < beats; i++) begin
      if (i > 0) nextCycle();
      r = row + 4'(i);
      checkOutput("burst_busy",    32'(bus.busy),    32'd1);
      checkOutput("burst_rom_row", 32'(bus.rom_row), 32'(r));
      checkOutput("burst_rom_sel", 32'(bus.rom_sel), 32'(car));
      checkOutput("burst_rom_ad",  32'(bus.rom_ad),  32'(ad));
      checkOutput("burst_gnt0",    32'(bus.gnt0),    32'(i == 0 && id == 0));
      checkOutput("burst_gnt1",    32'(bus.gnt1),    32'(i == 0 && id == 1));
      if (i == 1 && (otherMode == 1 || otherMode == 2)) begin
        if (id == 0) bus.req1 = 1'b1;
        else         bus.req0 = 1'b1;
      end
      if (i == 2 && otherMode == 1) begin
        if (id == 0) bus.req1 = 1'b0;
        else         bus.req0 = 1'b0;
      end
      if (i == 1 && otherMode == 3) begin
        if (id == 0) begin
          bus.car0 = ~car;
          bus.row0 = row + 4'd7;
        end else begin
          bus.car1 = ~car;
          bus.row1 = row + 4'd7;
        end
      end
    end
    nextCycle();
    checkOutput("end_busy",    32'(bus.busy),    32'd0);
    checkOutput("end_rom_sel", 32'(bus.rom_sel), 32'(SEL_BLANK));
    checkOutput("end_rom_ad",  32'(bus.rom_ad),  32'd0);
    checkOutput("end_rom_row", 32'(bus.rom_row), 32'd0);
  endtask

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      checkOutput("valid_exclusive", 32'(bus.rd_valid0 & bus.rd_valid1), 32'd0);
      if (bus.rd_valid0 || bus.rd_valid1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got beat data %0h, expected none", bus.rd_data);
        end else begin
          e = sb.pop_front();
          checkOutput("beat_id",   32'(bus.rd_valid1), 32'(e.id));
          checkOutput("beat_data", 32'(bus.rd_data),   32'(e.data));
          checkOutput("beat_last", 32'(bus.rd_last),   32'(e.last));
        end
      end else begin
        checkOutput("last_without_valid", 32'(bus.rd_last), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int who;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.car0 = 4'd0; bus.ad0 = 2'd0; bus.row0 = 4'd0; bus.len0 = 4'd0;
    bus.car1 = 4'd0; bus.ad1 = 2'd0; bus.row1 = 4'd0; bus.len1 = 4'd0;
    repeat (3) nextCycle();
    checkResetValues();

    // Single burst, requested before release so the synchroniser delay is visible.
    bus.car0 = 4'd1; bus.ad0 = 2'd2; bus.row0 = 4'd3; bus.len0 = 4'd4; bus.req0 = 1'b1;
    reset = 1'b1;
    nextCycle();
    checkOutput("no_grant_first_edge", 32'(bus.gnt0), 32'd0);
    applyStimulus(0, 4'd1, 2'd2, 4'd3, 4'd4, 5, 0, 2'b01);
    repeat (2) nextCycle();

    // Tie after reset: requester 0 first, then strict alternation.
    reset = 1'b0;
    nextCycle();
    reset = 1'b1;
    bus.car0 = 4'd2; bus.ad0 = 2'd1; bus.row0 = 4'd0; bus.len0 = 4'd2;
    bus.car1 = 4'd7; bus.ad1 = 2'd3; bus.row1 = 4'd9; bus.len1 = 4'd3;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    applyStimulus(0, 4'd2, 2'd1, 4'd0, 4'd2, 6, 0, 2'b00);
    applyStimulus(1, 4'd7, 2'd3, 4'd9, 4'd3, 1, 0, 2'b00);
    applyStimulus(0, 4'd2, 2'd1, 4'd0, 4'd2, 1, 0, 2'b11);
    repeat (2) nextCycle();

    // Row wrap with len=0 meaning sixteen rows.
    bus.car1 = 4'd5; bus.ad1 = 2'd1; bus.row1 = 4'd14; bus.len1 = 4'd0; bus.req1 = 1'b1;
    applyStimulus(1, 4'd5, 2'd1, 4'd14, 4'd0, 3, 0, 2'b10);
    repeat (2) nextCycle();

    // A request pulsed and dropped during another burst is never granted.
    bus.car0 = 4'd3; bus.ad0 = 2'd0; bus.row0 = 4'd6; bus.len0 = 4'd4; bus.req0 = 1'b1;
    bus.car1 = 4'd9; bus.ad1 = 2'd2; bus.row1 = 4'd1; bus.len1 = 4'd2;
    applyStimulus(0, 4'd3, 2'd0, 4'd6, 4'd4, 3, 1, 2'b01);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("dropped_req_gnt1", 32'(bus.gnt1), 32'd0);
      checkOutput("dropped_req_busy", 32'(bus.busy), 32'd0);
    end

    // A request held into IDLE is granted on the first IDLE edge.
    bus.req0 = 1'b1;
    applyStimulus(0, 4'd3, 2'd0, 4'd6, 4'd4, 3, 2, 2'b01);
    applyStimulus(1, 4'd9, 2'd2, 4'd1, 4'd2, 1, 0, 2'b10);
    repeat (2) nextCycle();

    // Fields changing after the grant must not affect the burst.
    bus.car0 = 4'd4; bus.ad0 = 2'd3; bus.row0 = 4'd10; bus.len0 = 4'd3; bus.req0 = 1'b1;
    applyStimulus(0, 4'd4, 2'd3, 4'd10, 4'd3, 3, 3, 2'b01);
    repeat (2) nextCycle();

    // Reset on the second beat of an eight-row burst: only the first beat survives.
    bus.car0 = 4'd6; bus.ad0 = 2'd2; bus.row0 = 4'd0; bus.len0 = 4'd8; bus.req0 = 1'b1;
    sb.push_back('{id: 1'b0, data: romModel(4'd6, 2'd2, 4'd0), last: 1'b0});
    waitGrant(3, who);
    bus.req0 = 1'b0;
    checkOutput("midrst_grant_id", 32'(who), 32'd0);
    nextCycle();
    nextCycle();
    checkOutput("midrst_second_beat", 32'(bus.rd_valid0), 32'd1);
    reset = 1'b0;
    #1;
    checkResetValues();
    repeat (2) nextCycle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("post_rst_valid0",  32'(bus.rd_valid0), 32'd0);
      checkOutput("post_rst_last",    32'(bus.rd_last),   32'd0);
      checkOutput("post_rst_busy",    32'(bus.busy),      32'd0);
      checkOutput("post_rst_rom_sel", 32'(bus.rom_sel),   32'(SEL_BLANK));
    end

    repeat (3) nextCycle();
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/font_rom_sequencer.md
FONT_ROM_SEQUENCER -- requirements
Module: font_rom_sequencer

Interface
REQ-001 The block SHALL have one parameter: SEL_BLANK, default 4'd15, the character-bank select driven to the ROM when no burst is active.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- req0 / req1  in  1  burst request from requester 0 (text labels) / requester 1 (RTC digits).
- car0 / car1  in  4  character-bank select for the burst.
- ad0 / ad1  in  2  character address within the bank.
- row0 / row1  in  4  first glyph row of the burst.
- len0 / len1  in  4  rows in the burst; 0 means 16.
- gnt0 / gnt1  out  1  one-cycle pulse when that burst is accepted.
- rom_sel  out  4  registered bank select to the font ROM.
- rom_ad  out  2  registered character address to the ROM.
- rom_row  out  4  registered glyph row to the ROM.
- rom_data  in  8  combinational ROM output for the current rom_* address.
- rd_data  out  8  registered glyph row returned to the requester.
- rd_valid0 / rd_valid1  out  1  rd_data is valid for requester 0 / 1.
- rd_last  out  1  rd_data is the final row of the burst.
- busy  out  1  high while a burst is in progress.

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, BURST0 and BURST1.
REQ-004 In IDLE, at each clock edge, the block SHALL sample req0 and req1.
- If neither is high, it stays in IDLE.
- If exactly one is high, that requester wins.
- If both are high, the requester not granted most recently wins (round-robin).
REQ-005 On a win, in the same edge, the block SHALL:
- enter BURSTn;
- pulse gntn high for exactly one cycle;
- latch carn, adn and rown into rom_sel, rom_ad and rom_row;
- load the remaining-row counter with lenn (0 loads 16; counter is 5 bits).
REQ-006 The requester SHALL hold its fields stable while reqn is high and ungranted; after gntn the block no longer depends on those inputs.
REQ-007 At each edge in BURSTn, the block SHALL:
- capture rom_data into rd_data;
- assert rd_validn for the following cycle;
- increment rom_row modulo 16 (15 wraps to 0);
- decrement the counter.
REQ-008 At the edge where the counter equals 1, the block SHALL also:
- assert rd_last with that beat;
- return to IDLE;
- drive rom_sel to SEL_BLANK, and rom_ad and rom_row to 0.
REQ-009 Latency SHALL be as follows:
- the first rd_validn is the cycle after gntn;
- rows follow one per cycle with no gaps;
- a burst of L rows holds busy for exactly L cycles, starting the cycle gntn is high.
REQ-010 After each burst the block SHALL spend at least one IDLE cycle (busy low) before the next grant.
REQ-011 The block SHALL ignore req0 and req1 outside IDLE. A request still held when IDLE is re-entered is treated as a new request.
REQ-012 rd_valid0 and rd_valid1 SHALL never be high together, and neither SHALL be high in IDLE except for the final beat.
REQ-013 rd_data SHALL hold its last value when no valid is asserted.
REQ-014 busy SHALL be high exactly when the state is BURST0 or BURST1.
REQ-015 The last-granted register SHALL update only on a grant.

Reset
REQ-016 While reset is low, the block SHALL force all of the following, asynchronously:
- state = IDLE;
- gnt0 = gnt1 = 0;
- rd_valid0 = rd_valid1 = 0, rd_last = 0;
- busy = 0;
- rd_data = 8'h00;
- rom_sel = SEL_BLANK, rom_ad = 0, rom_row = 0;
- counter = 0;
- last-granted = requester 1, so requester 0 wins the first tie.
REQ-017 If reset asserts mid-burst, the block SHALL abort the burst without emitting rd_last. After reset releases, no beats of the aborted burst SHALL appear.
REQ-018 Reset release SHALL be synchronised internally; the first grant can occur no earlier than the second rising clk edge after release.

Verification
REQ-019 The verification bench SHALL cover the following directed scenarios (stimulus -> required response):
- Single burst: req0, car0=1, ad0=2, row0=3, len0=4 -> gnt0 one cycle; rom_row 3,4,5,6; four rd_valid0 beats with rd_data equal to the ROM model; rd_last on the 4th; busy high 4 cycles.
- Tie: req0 and req1 both high after reset -> gnt0 first. Then, with both still high -> gnt1 next, then gnt0, alternating; one IDLE cycle between bursts.
- Wrap and len=0: req1, row1=14, len1=0 -> 16 beats; rom_row 14,15,0,...,13; rd_last only on the 16th beat.
- Request during burst: req1 pulses while BURST0 is active and is dropped before IDLE -> no gnt1; req1 held into IDLE -> gnt1 on the first IDLE edge.
- Mid-burst reset: reset low on the 2nd beat of an 8-row burst -> all outputs at reset values immediately; no rd_last; after release, IDLE with rom_sel=15.
- Input change after grant: car0 and row0 change the cycle after gnt0 -> burst uses the latched values.
